seven_seg_mux_driver: RTL and testbench

- Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits sharing one active-low segment bus.
- Cycles through the digits at a fixed slot rate and inserts a dead-time gap before each slot to suppress ghosting.
- Each digit has its own blank enable and decimal point, and a digit's value is latched once per slot so it cannot change partway through a slot.
- Sits between the lab datapath (hex nibbles) and the board pins, replacing the per-digit combinational decoders.

---
 rtl/seven_seg_pkg.sv | 31 +++
 rtl/seg_slot_timer.sv | 64 ++++++
 rtl/seven_seg_mux_driver.sv | 111 +++++++++++
 tb/tb_seven_seg_mux_driver.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and helpers for the multiplexed
// seven-segment driver.
//   HEX_SEG     - active-low segment patterns for hex 0..F, {a,b,c,d,e,f,g}
//   SEG_BLANK   - all segments dark
//   slot_hold_t - per-slot snapshot of one digit's inputs
//   anode_level - physical anode pin level for a logical select
//   ctr_width   - counter width helper (never less than 1 bit)
package seven_seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h72, 7'h42, 7'h10, 7'h38
  };

  typedef struct packed {
    logic       en;
    logic       dp;
    logic [3:0] nib;
  } slot_hold_t;

  function automatic logic anode_level(input logic active, input bit active_low);
    return active_low ? ~active : active;
  endfunction

  function automatic int unsigned ctr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seg_slot_timer.sv
// seg_slot_timer: slot counter and digit-slot sequencer.
//   clk_i, rst_i   - clock, async active-high reset
//   slot_idx_o     - digit currently owning the segment bus (registered)
//   slot_nxt_o     - slot index for the cycle about to start
//   slot_wrap_o    - high in the last cycle of a slot (next edge starts a new slot)
//   in_dead_o      - the cycle about to start lies in the dead-time gap
//   frame_start_o  - registered one-cycle pulse in the first cycle of slot 0
module seg_slot_timer
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 2,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  output logic [ctr_width(NUM_DIGITS)-1:0]   slot_idx_o,
  output logic [ctr_width(NUM_DIGITS)-1:0]   slot_nxt_o,
  output logic                               slot_wrap_o,
  output logic                               in_dead_o,
  output logic                               frame_start_o
);

  localparam int unsigned CNTW = ctr_width(REFRESH_DIV);
  localparam int unsigned IDXW = ctr_width(NUM_DIGITS);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDXW-1:0] slot_q, slot_d;
  logic            frame_q, frame_d;
  logic            wrap;

  assign wrap = (cnt_q == CNTW'(REFRESH_DIV - 1));

  always_comb begin
    cnt_d   = cnt_q + CNTW'(1);
    slot_d  = slot_q;
    frame_d = 1'b0;
    if (wrap) begin
      cnt_d   = '0;
      slot_d  = (slot_q == IDXW'(NUM_DIGITS - 1)) ? '0 : slot_q + IDXW'(1);
      frame_d = (slot_d == '0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      slot_q  <= '0;
      frame_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      frame_q <= frame_d;
    end
  end

  // Next-state views let the parent register its outputs with zero lag.
  assign slot_idx_o    = slot_q;
  assign slot_nxt_o    = slot_d;
  assign slot_wrap_o   = wrap;
  assign in_dead_o     = (cnt_d < CNTW'(DEAD_CYCLES));
  assign frame_start_o = frame_q;

endmodule

// File: rtl/seven_seg_mux_driver.sv
// seven_seg_mux_driver: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits on one shared active-low segment bus.
//   clk, reset   - clock, async active-high reset
//   digits       - hex nibbles, digit i = digits[4i+3:4i]
//   digit_en     - per-digit show enable (0 blanks the digit)
//   dp           - per-digit decimal point request
//   seg          - active-low segments, seg[6]=a .. seg[0]=g
//   seg_dp       - active-low decimal point
//   anode        - digit selects, polarity from ANODE_ACTIVE_LOW
//   slot_idx     - digit currently owning the bus
//   frame_start  - one-cycle pulse at the start of slot 0
// Every output is a flop; inputs are only sampled at slot boundaries.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 2,
  parameter int unsigned REFRESH_DIV      = 100000,
  parameter int unsigned DEAD_CYCLES      = 16,
  parameter int unsigned ANODE_ACTIVE_LOW = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [4*NUM_DIGITS-1:0]          digits,
  input  logic [NUM_DIGITS-1:0]            digit_en,
  input  logic [NUM_DIGITS-1:0]            dp,
  output logic [6:0]                       seg,
  output logic                             seg_dp,
  output logic [NUM_DIGITS-1:0]            anode,
  output logic [ctr_width(NUM_DIGITS)-1:0] slot_idx,
  output logic                             frame_start
);

  localparam int unsigned IDXW     = ctr_width(NUM_DIGITS);
  localparam bit          ANODE_LO = (ANODE_ACTIVE_LOW != 0);

  logic [IDXW-1:0] slot_nxt;
  logic            slot_wrap;
  logic            dead_nxt;

  seg_slot_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk_i         (clk),
    .rst_i         (reset),
    .slot_idx_o    (slot_idx),
    .slot_nxt_o    (slot_nxt),
    .slot_wrap_o   (slot_wrap),
    .in_dead_o     (dead_nxt),
    .frame_start_o (frame_start)
  );

  slot_hold_t            hold_q, hold_d;
  slot_hold_t            sel;
  logic                  on_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [NUM_DIGITS-1:0] anode_idle;

  always_comb begin
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      anode_idle[i] = anode_level(1'b0, ANODE_LO);
    end
  end

  // Select the inputs belonging to the slot about to begin.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (slot_nxt == IDXW'(i)) begin
        sel.en  = digit_en[i];
        sel.dp  = dp[i];
        sel.nib = digits[4*i +: 4];
      end
    end
  end

  assign hold_d = slot_wrap ? sel : hold_q;

  // Outputs are computed from next-state values so the registered pins
  // line up exactly with the cycle's slot, phase and held digit.
  always_comb begin
    on_d     = hold_d.en && !dead_nxt;
    seg_d    = on_d ? HEX_SEG[hold_d.nib] : SEG_BLANK;
    seg_dp_d = on_d ? ~hold_d.dp : 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      anode_d[i] = anode_level(on_d && (slot_nxt == IDXW'(i)), ANODE_LO);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q   <= '0;
      seg_q    <= SEG_BLANK;
      seg_dp_q <= 1'b1;
      anode_q  <= anode_idle;
    end else begin
      hold_q   <= hold_d;
      seg_q    <= seg_d;
      seg_dp_q <= seg_dp_d;
      anode_q  <= anode_d;
    end
  end

  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;
  assign anode  = anode_q;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Bench for seven_seg_mux_driver with NUM_DIGITS=2, REFRESH_DIV=8,
// DEAD_CYCLES=2, active-low anodes. A cycle-count model derives every
// output from elapsed time since reset plus per-slot input snapshots.
module tb_seven_seg_mux_driver;

  localparam int ND = 2;
  localparam int RD = 8;
  localparam int DC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] digits = 8'h3A;
  logic [1:0] digit_en = 2'b11;
  logic [1:0] dp = 2'b01;
  logic [6:0] seg;
  logic       seg_dp;
  logic [1:0] anode;
  logic [0:0] slot_idx;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h72, 7'h42, 7'h10, 7'h38
  };

  seven_seg_mux_driver #(
    .NUM_DIGITS       (ND),
    .REFRESH_DIV      (RD),
    .DEAD_CYCLES      (DC),
    .ANODE_ACTIVE_LOW (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .digit_en    (digit_en),
    .dp          (dp),
    .seg         (seg),
    .seg_dp      (seg_dp),
    .anode       (anode),
    .slot_idx    (slot_idx),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  // Model: t = cycles elapsed since reset release; snapshots taken when a
  // new slot begins (t a multiple of RD, t > 0).
  int         t = 0;
  logic       snap_en  [ND] = '{1'b0, 1'b0};
  logic       snap_dp  [ND] = '{1'b0, 1'b0};
  logic [3:0] snap_nib [ND] = '{4'h0, 4'h0};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t        <= 0;
      snap_en  <= '{1'b0, 1'b0};
      snap_dp  <= '{1'b0, 1'b0};
      snap_nib <= '{4'h0, 4'h0};
    end else begin
      t <= t + 1;
      if ((t + 1) % RD == 0) begin
        snap_en[((t + 1) / RD) % ND]  <= digit_en[((t + 1) / RD) % ND];
        snap_dp[((t + 1) / RD) % ND]  <= dp[((t + 1) / RD) % ND];
        snap_nib[((t + 1) / RD) % ND] <= digits[4 * (((t + 1) / RD) % ND) +: 4];
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int         cnt, slot;
    logic       on;
    logic [1:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fr;
    if (reset) begin
      slot = 0; e_an = 2'b11; e_seg = 7'h7F; e_dp = 1'b1; e_fr = 1'b0;
    end else begin
      cnt   = t % RD;
      slot  = (t / RD) % ND;
      on    = (cnt >= DC) && snap_en[slot];
      e_an  = on ? ~(2'b01 << slot) : 2'b11;
      e_seg = on ? hex_tab[snap_nib[slot]] : 7'h7F;
      e_dp  = on ? ~snap_dp[slot] : 1'b1;
      e_fr  = (t > 0) && (t % (ND * RD) == 0);
    end
    cmp("m_anode", anode, e_an);
    cmp("m_seg", seg, e_seg);
    cmp("m_seg_dp", seg_dp, e_dp);
    cmp("m_slot_idx", slot_idx, slot);
    cmp("m_frame_start", frame_start, e_fr);
    checks++;
    assert ($onehot0(~anode)) else begin
      errors++;
      $display("FAIL anode_onehot0 t=%0d: got %b expected at most one low", t, anode);
    end
  end

  task automatic goto(input int target);
    int guard = 0;
    while (t != target && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (t != target) begin
      errors++;
      $display("FAIL goto_timeout: got t=%0d expected t=%0d", t, target);
    end
  endtask

  task automatic lit(input string name, input logic [1:0] e_an,
                     input logic [6:0] e_seg, input logic e_dp);
    cmp({name, "_anode"}, anode, e_an);
    cmp({name, "_seg"}, seg, e_seg);
    cmp({name, "_seg_dp"}, seg_dp, e_dp);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    lit("reset_state", 2'b11, 7'h7F, 1'b1);

    goto(2);  lit("first_slot_blank", 2'b11, 7'h7F, 1'b1);
    goto(13); lit("slot1_pre_reset", 2'b01, 7'h06, 1'b1);

    // Asynchronous reset at slot 1, cnt 5.
    #2 reset = 1'b1;
    #1;
    lit("async_reset", 2'b11, 7'h7F, 1'b1);
    cmp("async_reset_slot", slot_idx, 0);
    @(negedge clk);
    #1 reset = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
    cmp("first_frame_delay", n, 16);

    lit("slot0_dead", 2'b11, 7'h7F, 1'b1);
    goto(18); lit("slot0_on_A", 2'b10, 7'h08, 1'b0);
    goto(20); digits = 8'h3F;
    goto(23); lit("tear_free", 2'b10, 7'h08, 1'b0);
    goto(26); lit("slot1_on_3", 2'b01, 7'h06, 1'b1);
    goto(34); lit("slot0_new_F", 2'b10, 7'h38, 1'b0);

    digit_en = 2'b01;
    for (int c = 40; c < 48; c++) begin
      goto(c); lit("slot1_blanked", 2'b11, 7'h7F, 1'b1);
    end
    goto(50); lit("slot0_unaffected", 2'b10, 7'h38, 1'b0);

    digit_en = 2'b11;
    dp = 2'b00;
    for (int k = 0; k < 16; k++) begin
      goto(16 * (k + 4) - 5);
      digits = {4'h3, 4'(k)};
      goto(16 * (k + 4) + 3);
      lit("sweep", 2'b10, hex_tab[k], 1'b1);
    end

    goto(16 * 20 + 4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
